// File: rtl/uart_rx_fifo_if.sv
// Avalon-MM slave bundle for uart_rx_fifo; signal names match the platform
// conduit so the component can be wired directly to the interconnect.
interface uart_rx_fifo_if;
   // No waitrequest: a read or write strobe is accepted on every cycle it is
   // high, and readdata is valid exactly one cycle after the read strobe.
   logic [1:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a
// power-of-two receive FIFO behind a 4-register Avalon-MM slave.
module uart_rx_fifo #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          uart_rx,
   uart_rx_fifo_if.slave avs,
   output logic          irq,
   output logic [2:0]    dbg_state_o,
   output logic          dbg_push_o
);
   localparam int DIV = CLK_HZ / (BAUD * 16);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
   } state_t;
`endif

   logic sync1_q, sync2_q, prev_q;
   logic rx_s, fall;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= uart_rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rx_s = sync2_q;
   assign fall = prev_q & ~sync2_q;

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;

   assign tick = (tick_cnt_q == TW'(DIV - 1));

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   state_t     state_q, state_d;
   logic [3:0] samp_q, samp_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       wait_q, wait_d;
   logic       push, fe_set, mid;
`ifdef UART_RX_PARITY_EN
   logic       par_bad_q, par_bad_d;
   logic       pe_set;
`endif

   assign mid = tick && (samp_q == 4'd15);

   always_comb begin
      state_d = state_q;
      samp_d  = samp_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      wait_d  = wait_q;
      push    = 1'b0;
      fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      pe_set    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d = S_START;
               samp_d  = 4'd0;
            end
         end
         S_START: begin
            if (tick) begin
               samp_d = samp_q + 4'd1;
               if (samp_q == 4'd7) begin
                  samp_d  = 4'd0;
                  bit_d   = 3'd0;
                  state_d = rx_s ? S_IDLE : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               samp_d = samp_q + 4'd1;
               if (mid) begin
                  shift_d = {rx_s, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     wait_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               samp_d = samp_q + 4'd1;
               if (mid) begin
                  par_bad_d = (rx_s != ^shift_q);
                  pe_set    = (rx_s != ^shift_q);
                  state_d   = S_STOP;
               end
            end
         end
`endif
         S_STOP: begin
            // After a low stop bit, hold here until the line idles high again.
            if (wait_q) begin
               if (rx_s) begin
                  wait_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end else if (tick) begin
               samp_d = samp_q + 4'd1;
               if (mid) begin
                  if (rx_s) begin
                     state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                     push    = ~par_bad_q;
`else
                     push    = 1'b1;
`endif
                  end else begin
                     fe_set = 1'b1;
                     wait_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_q <= '0;
         state_q    <= S_IDLE;
         samp_q     <= 4'd0;
         bit_q      <= 3'd0;
         shift_q    <= 8'd0;
         wait_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q  <= 1'b0;
`endif
      end else begin
         tick_cnt_q <= tick_cnt_d;
         state_q    <= state_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         wait_q     <= wait_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q  <= par_bad_d;
`endif
      end
   end

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty, full, pop, do_push, oe_set, flush, st_wr, ctrl_wr;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign pop     = avs.avs_read && (avs.avs_address == 2'd0) && !empty;
   assign flush   = avs.avs_write && (avs.avs_address == 2'd2) && avs.avs_writedata[1];
   assign st_wr   = avs.avs_write && (avs.avs_address == 2'd1);
   assign ctrl_wr = avs.avs_write && (avs.avs_address == 2'd2);
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || pop) && !flush;
   assign oe_set  = push && full && !pop && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= shift_q;
   end

   logic        oe_q, oe_d, fe_q, fe_d, ie_q, ie_d;
   logic [31:0] status, rdata_q, rdata_d;
`ifdef UART_RX_PARITY_EN
   logic        pe_q, pe_d;
`endif

   always_comb begin
      oe_d = oe_set | (oe_q & ~(st_wr & avs.avs_writedata[2]));
      fe_d = fe_set | (fe_q & ~(st_wr & avs.avs_writedata[3]));
`ifdef UART_RX_PARITY_EN
      pe_d = pe_set | (pe_q & ~(st_wr & avs.avs_writedata[4]));
`endif
      ie_d = ctrl_wr ? avs.avs_writedata[0] : ie_q;

      status       = '0;
      status[0]    = ~empty;
      status[1]    = full;
      status[2]    = oe_q;
      status[3]    = fe_q;
`ifdef UART_RX_PARITY_EN
      status[4]    = pe_q;
`endif
      status[14:8] = 7'(count_q);

      rdata_d = '0;
      if (avs.avs_read) begin
         case (avs.avs_address)
            2'd0:    if (!empty) rdata_d[7:0] = mem_q[rd_ptr_q];
            2'd1:    rdata_d = status;
            2'd2:    rdata_d[0] = ie_q;
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         oe_q     <= 1'b0;
         fe_q     <= 1'b0;
         ie_q     <= 1'b0;
         rdata_q  <= '0;
`ifdef UART_RX_PARITY_EN
         pe_q     <= 1'b0;
`endif
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         oe_q     <= oe_d;
         fe_q     <= fe_d;
         ie_q     <= ie_d;
         rdata_q  <= rdata_d;
`ifdef UART_RX_PARITY_EN
         pe_q     <= pe_d;
`endif
      end
   end

   logic unused_wdata;
   assign unused_wdata = ^avs.avs_writedata[31:4];

   assign avs.avs_readdata = rdata_q;
   assign irq              = ~empty & ie_q;
   assign dbg_state_o      = state_q;
   assign dbg_push_o       = push;
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries, a power of two from 2 to 64.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port uart_rx, input, 1: asynchronous serial line, idle high; exported as the system conduit.
REQ-007 SHALL have port avs_address, input, 2: register select.
REQ-008 SHALL have port avs_read, input, 1: Avalon-MM read strobe.
REQ-009 SHALL have port avs_write, input, 1: Avalon-MM write strobe.
REQ-010 SHALL have port avs_writedata, input, 32: write data.
REQ-011 SHALL have port avs_readdata, output, 32: read data, fixed read latency of 1 cycle.
REQ-012 SHALL have port irq, output, 1: level interrupt, high while FIFO is non-empty and bit 0 of CTRL is set.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer; the synchronizers reset to 1.
REQ-014 SHALL generate a 16x oversample tick every DIV = CLK_HZ/(BAUD*16) clocks (integer divide; 27 at the defaults); the tick counter wraps at DIV-1.
REQ-015 SHALL use receiver FSM states IDLE, START, DATA, STOP:
- IDLE -> START on a synchronized falling edge.
- START: at sample 8, line low -> DATA; line high -> IDLE (glitch rejected, nothing stored).
- DATA: samples 8 data bits LSB first, one every 16 ticks at mid-bit.
- STOP: samples mid-bit, then returns to IDLE.
REQ-016 SHALL push the byte into the FIFO on the cycle STOP samples a high stop bit.
REQ-017 SHALL, when STOP samples low: discard the byte, set sticky FE, and stay in STOP until the line returns high.
REQ-018 SHALL, on a push while the FIFO is full: drop the new byte, set sticky OE, and leave the FIFO unchanged.
REQ-019 SHALL define the register map:
- addr 0 DATA (RO): bits[7:0] = FIFO head, bits[31:8] = 0. A read pops one entry; a read when empty returns 0 and does not pop.
- addr 1 STATUS: bit0 = not empty, bit1 = full, bit2 = OE, bit3 = FE, bits[14:8] = entry count. Writing 1 to bit2 or bit3 clears that bit.
- addr 2 CTRL (RW): bit0 = irq enable, bit1 = FIFO flush (self-clearing).
- addr 3: reads 0, writes ignored.
REQ-020 SHALL, on the same cycle a push and a DATA-read pop occur with the FIFO non-empty: perform both, count unchanged.
REQ-021 SHALL, on the same cycle a push and a DATA-read pop occur with the FIFO full: pop first, then push; no OE.
REQ-022 SHALL, when a flush coincides with a push: discard both; count becomes 0.
REQ-023 SHALL keep the FIFO pointers FIFO_DEPTH-wrapping, with the count held at log2(FIFO_DEPTH)+1 bits.

Reset
REQ-024 SHALL, while reset is high, force on the next edge: FSM = IDLE; tick, bit and sample counters = 0; FIFO count and pointers = 0; OE = FE = 0; CTRL = 0; avs_readdata = 0; irq = 0.
REQ-025 SHALL discard a frame in progress when reset is asserted mid-frame; no partial byte is stored.

Configuration
REQ-026 SHALL use macro UART_RX_PARITY_EN to select parity checking.
- Defined: the frame is 8E1, with an extra PARITY state between DATA and STOP. A parity mismatch discards the byte and sets sticky PE at STATUS bit4; writing 1 to bit4 clears it.
- Undefined: the frame is 8N1, there is no PARITY state, and STATUS bit4 reads 0.

Verification
REQ-027 SHALL cover: 8N1 frame 0x55 at 115200 -> STATUS = 0x0000_0101; a DATA read returns 0x55 one cycle later; STATUS then = 0.
REQ-028 SHALL cover: 0x3C sent with the stop bit low -> FIFO stays empty, STATUS bit3 = 1; writing 0x8 to STATUS clears it.
REQ-029 SHALL cover: 17 bytes 0x00..0x10 with no reads -> count = 16, full = 1, OE = 1; reads return 0x00..0x0F in order.
REQ-030 SHALL cover: low pulse of 100 clocks on idle uart_rx -> no push, FSM back in IDLE, STATUS = 0.
REQ-031 SHALL cover: DATA read on the same cycle as the STOP-bit push, with 1 entry held -> count stays 1; the read returns the older byte.
REQ-032 SHALL cover: reset pulsed during bit 4 of frame 0xA5, then a clean 0x5A sent -> the FIFO holds only 0x5A.
